// File: rtl/responder_display.sv
`timescale 1ns/1ps
// responder_display: multiplexes the four quiz scores onto an 8-digit 7-segment
// display (tens/units per player), blinks the winner's digits and drives the
// "answering" LEDs. All outputs are registered.
module responder_display #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] P,
    input  logic [3:0] p1_score,
    input  logic [3:0] p2_score,
    input  logic [3:0] p3_score,
    input  logic [3:0] p4_score,
    input  logic [2:0] winner,
    output logic [6:0] seg,
    output logic [7:0] dig,
    output logic [3:0] led
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Scan timing state
    logic [PW-1:0]   prescaler_q, prescaler_d;
    logic [2:0]      idx_q, idx_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            blink_q, blink_d;
    logic            tick, wrap;

    // Per-frame snapshot of the scan inputs; index 0 is player 1
    logic [3:0][3:0] shadow_scores_q;
    logic [2:0]      shadow_winner_q;
    logic [3:0][3:0] live_scores;

    // Digit content for the slot being entered on this tick
    logic [3:0][3:0] sel_scores;
    logic [2:0]      sel_winner;
    logic            sel_phase;
    logic [1:0]      player;
    logic [3:0]      score;
    logic [3:0]      units;
    logic            tens;
    logic            blank;
    logic [6:0]      digit_seg;

    logic [6:0]      seg_q, seg_d;
    logic [7:0]      dig_q, dig_d;
    logic [3:0]      led_q, led_d;

    assign live_scores = {p4_score, p3_score, p2_score, p1_score};

    assign seg = seg_q;
    assign dig = dig_q;
    assign led = led_q;

    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Prescaler, scan index and blink frame counter next-state
    always_comb begin
        tick        = (prescaler_q == PRESC_LAST);
        prescaler_d = tick ? '0 : prescaler_q + PW'(1);
        idx_d       = idx_q + 3'd1;
        wrap        = tick && (idx_q == 3'd7);
        frame_d     = (frame_q == FRAME_LAST) ? '0 : frame_q + FW'(1);
        blink_d     = (frame_q == FRAME_LAST) ? ~blink_q : blink_q;
    end

    // Digit content: the wrap tick bypasses the snapshot so the whole new frame
    // (digit 0 included) sees the same scores, winner and blink phase
    always_comb begin
        sel_scores = wrap ? live_scores : shadow_scores_q;
        sel_winner = wrap ? winner : shadow_winner_q;
        sel_phase  = wrap ? blink_d : blink_q;
        player     = idx_d[2:1];
        score      = sel_scores[player];
        tens       = (score >= 4'd10);
        units      = tens ? score - 4'd10 : score;
        digit_seg  = idx_d[0] ? seg_encode(units) : (tens ? 7'h06 : 7'h00);
        blank      = sel_phase && (sel_winner >= 3'd1) && (sel_winner <= 3'd4) &&
                     ((sel_winner - 3'd1) == {1'b0, player});
        seg_d      = blank ? 7'h00 : digit_seg;
        dig_d      = ~(8'h01 << idx_d);
    end

    // Answering LED decode
    always_comb begin
        led_d = 4'h0;
        case (P)
            3'd1:    led_d = 4'b0001;
            3'd2:    led_d = 4'b0010;
            3'd3:    led_d = 4'b0100;
            3'd4:    led_d = 4'b1000;
            default: led_d = 4'h0;
        endcase
    end

    // Scan state, snapshot and display registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q     <= '0;
            idx_q           <= 3'd7;
            frame_q         <= '0;
            blink_q         <= 1'b0;
            shadow_scores_q <= '0;
            shadow_winner_q <= 3'd0;
            seg_q           <= 7'h00;
            dig_q           <= 8'hFF;
        end else begin
            prescaler_q <= prescaler_d;
            if (tick) begin
                idx_q <= idx_d;
                seg_q <= seg_d;
                dig_q <= dig_d;
            end
            if (wrap) begin
                shadow_scores_q <= live_scores;
                shadow_winner_q <= winner;
                frame_q         <= frame_d;
                blink_q         <= blink_d;
            end
        end
    end

    // LED register, updated every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= 4'h0;
        end else begin
            led_q <= led_d;
        end
    end

endmodule

// File: tb/tb_responder_display.sv
`timescale 1ns/1ps
// Directed bench for responder_display with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_responder_display;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned BLINK_FRAMES = 2;

    // Expected frame contents, digit 0 in the top 7 bits
    localparam logic [55:0] F_VIS = {7'h00, 7'h07, 7'h00, 7'h6D, 7'h06, 7'h6D, 7'h06, 7'h6D};
    localparam logic [55:0] F_BLK = {7'h00, 7'h07, 7'h00, 7'h6D, 7'h00, 7'h00, 7'h06, 7'h6D};

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] P;
    logic [3:0] p1_score, p2_score, p3_score, p4_score;
    logic [2:0] winner;
    logic [6:0] seg;
    logic [7:0] dig;
    logic [3:0] led;

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_seg_now;
    logic [7:0] exp_dig_now;

    always #5 clk = ~clk;

    responder_display #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .P       (P),
        .p1_score(p1_score),
        .p2_score(p2_score),
        .p3_score(p3_score),
        .p4_score(p4_score),
        .winner  (winner),
        .seg     (seg),
        .dig     (dig),
        .led     (led)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks the outputs hold for the three cycles before a tick, then the new digit
    task automatic tick_check(input string tag, input int i, input logic [6:0] exp_seg);
        logic [7:0] exp_dig;
        repeat (SCAN_DIV - 1) @(posedge clk);
        #1;
        check_eq($sformatf("%s_d%0d_hold_seg", tag, i), {25'd0, seg}, {25'd0, exp_seg_now});
        check_eq($sformatf("%s_d%0d_hold_dig", tag, i), {24'd0, dig}, {24'd0, exp_dig_now});
        @(posedge clk);
        #1;
        exp_dig = ~(8'h01 << i);
        check_eq($sformatf("%s_d%0d_seg", tag, i), {25'd0, seg}, {25'd0, exp_seg});
        check_eq($sformatf("%s_d%0d_dig", tag, i), {24'd0, dig}, {24'd0, exp_dig});
        exp_seg_now = exp_seg;
        exp_dig_now = exp_dig;
    endtask

    task automatic run_frame(input string tag, input logic [55:0] segs);
        for (int i = 0; i < 8; i++) begin
            tick_check(tag, i, segs[55-7*i -: 7]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] p_seq [5];
        logic [3:0] led_exp [5];
        logic [55:0] f2;
        p_seq   = '{3'd0, 3'd2, 3'd4, 3'd5, 3'd1};
        led_exp = '{4'h0, 4'h2, 4'h8, 4'h0, 4'h1};
        f2      = {7'h00, 7'h4F, 7'h00, 7'h6F, 7'h06, 7'h3F, 7'h06, 7'h6D};

        reset    = 1'b1;
        P        = 3'd0;
        p1_score = 4'd0;
        p2_score = 4'd9;
        p3_score = 4'd10;
        p4_score = 4'd15;
        winner   = 3'd0;
        exp_seg_now = 7'h00;
        exp_dig_now = 8'hFF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_seg", {25'd0, seg}, 32'h00);
        check_eq("reset_dig", {24'd0, dig}, 32'hFF);
        check_eq("reset_led", {28'd0, led}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Frame 1: score conversion 0, 9, 10, 15
        run_frame("f1", {7'h00, 7'h3F, 7'h00, 7'h6F, 7'h06, 7'h3F, 7'h06, 7'h6D});

        // Frame 2: p1 goes live at the wrap; mid-frame changes stay hidden
        p1_score = 4'd3;
        for (int i = 0; i < 8; i++) begin
            tick_check("f2", i, f2[55-7*i -: 7]);
            if (i == 3) begin
                p1_score = 4'd7;
                p2_score = 4'd5;
                p3_score = 4'd2;
            end
        end

        // Frame 3: new snapshot
        run_frame("f3", {7'h00, 7'h07, 7'h00, 7'h6D, 7'h00, 7'h5B, 7'h06, 7'h6D});

        // Frames 4-9: winner 3 blinks with period two frames
        winner   = 3'd3;
        p3_score = 4'd15;
        run_frame("f4", F_VIS);
        run_frame("f5", F_VIS);
        run_frame("f6", F_BLK);
        run_frame("f7", F_BLK);
        run_frame("f8", F_VIS);
        run_frame("f9", F_VIS);

        // Frames 10-17: out-of-range winner never blanks
        winner = 3'd6;
        for (int f = 10; f < 18; f++) begin
            run_frame($sformatf("f%0d", f), F_VIS);
        end

        // Frames 18-20: winner 1 set just before the wrap, live bypass on digit 0
        winner   = 3'd1;
        p1_score = 4'd12;
        run_frame("f18", {7'h00, 7'h00, 7'h00, 7'h6D, 7'h06, 7'h6D, 7'h06, 7'h6D});
        run_frame("f19", {7'h00, 7'h00, 7'h00, 7'h6D, 7'h06, 7'h6D, 7'h06, 7'h6D});
        run_frame("f20", {7'h06, 7'h5B, 7'h00, 7'h6D, 7'h06, 7'h6D, 7'h06, 7'h6D});

        // LED decode, one cycle latency
        for (int i = 0; i < 5; i++) begin
            P = p_seq[i];
            @(posedge clk);
            #1;
            check_eq($sformatf("led_%0d", i), {28'd0, led}, {28'd0, led_exp[i]});
        end

        // Reset mid-scan is immediate, then scanning restarts at digit 0
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_seg", {25'd0, seg}, 32'h00);
        check_eq("midrst_dig", {24'd0, dig}, 32'hFF);
        check_eq("midrst_led", {28'd0, led}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_seg_now = 7'h00;
        exp_dig_now = 8'hFF;
        tick_check("rst", 0, 7'h06);
        check_eq("rst_led", {28'd0, led}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
